// File: rtl/wb_regfile.sv
// wb_regfile: parametrised writeback register file with two write ports
// (ALU result and load return), two combinational read ports and a
// per-register busy scoreboard for outstanding loads.
// Optional build macro WB_BYPASS_EN: same-cycle write-to-read forwarding.
// When WB_BYPASS_EN is undefined, reads see pre-edge contents, so a write
// becomes visible to a read one cycle later.
module wb_regfile #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wl_en,
    input  logic [AW-1:0]   wl_addr,
    input  logic [XLEN-1:0] wl_data,
    input  logic            issue_load,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   ra1_addr,
    output logic [XLEN-1:0] ra1_data,
    output logic            ra1_busy,
    input  logic [AW-1:0]   ra2_addr,
    output logic [XLEN-1:0] ra2_data,
    output logic            ra2_busy,
    output logic            wb_conflict
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic wa_hit;
    logic wl_hit;
    logic ld_hit;

    // An address is usable only if it names an implemented register and is
    // not the hardwired zero register.
    function automatic logic legal(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (int'(a) < NREGS);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    assign wa_hit = wa_en && legal(wa_addr);
    assign wl_hit = wl_en && legal(wl_addr);
    assign ld_hit = issue_load && legal(issue_rd);

    // Register array update; the ALU port overrides the load port on a collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wa_hit && (wa_addr == AW'(i))) begin
                    regs[i] <= wa_data;
                end else if (wl_hit && (wl_addr == AW'(i))) begin
                    regs[i] <= wl_data;
                end
            end
        end
    end

    // Scoreboard: a load issue sets busy, a load return clears it; set wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ld_hit && (issue_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wl_hit && (wl_addr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Flag a cycle in which both write ports targeted the same legal register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_conflict <= 1'b0;
        end else begin
            wb_conflict <= wa_hit && wl_hit && (wa_addr == wl_addr);
        end
    end

    // Read port 1: array lookup, optionally overridden by a same-cycle write.
    always_comb begin
        ra1_data = '0;
        ra1_busy = 1'b0;
        if (legal(ra1_addr)) begin
            for (int i = 0; i < NREGS; i++) begin
                if (ra1_addr == AW'(i)) begin
                    ra1_data = regs[i];
                    ra1_busy = busy[i];
                end
            end
`ifdef WB_BYPASS_EN
            if (wl_hit && (wl_addr == ra1_addr)) begin
                ra1_data = wl_data;
                if (!(ld_hit && (issue_rd == ra1_addr))) begin
                    ra1_busy = 1'b0;
                end
            end
            if (wa_hit && (wa_addr == ra1_addr)) begin
                ra1_data = wa_data;
            end
`endif
        end
    end

    // Read port 2: same structure as read port 1.
    always_comb begin
        ra2_data = '0;
        ra2_busy = 1'b0;
        if (legal(ra2_addr)) begin
            for (int i = 0; i < NREGS; i++) begin
                if (ra2_addr == AW'(i)) begin
                    ra2_data = regs[i];
                    ra2_busy = busy[i];
                end
            end
`ifdef WB_BYPASS_EN
            if (wl_hit && (wl_addr == ra2_addr)) begin
                ra2_data = wl_data;
                if (!(ld_hit && (issue_rd == ra2_addr))) begin
                    ra2_busy = 1'b0;
                end
            end
            if (wa_hit && (wa_addr == ra2_addr)) begin
                ra2_data = wa_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile (NREGS=16 build so out-of-range addresses exist).
// Directed steps from the test plan followed by randomized traffic checked
// against a behavioural model of the register file.
module tb_wb_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int AW    = 5;
    localparam int NADDR = 2 ** AW;

    logic            clock = 1'b0;
    logic            reset;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;
    logic            wl_en;
    logic [AW-1:0]   wl_addr;
    logic [XLEN-1:0] wl_data;
    logic            issue_load;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   ra1_addr;
    logic [XLEN-1:0] ra1_data;
    logic            ra1_busy;
    logic [AW-1:0]   ra2_addr;
    logic [XLEN-1:0] ra2_data;
    logic            ra2_busy;
    logic            wb_conflict;

    always #5 clock = ~clock;

    wb_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wl_en       (wl_en),
        .wl_addr     (wl_addr),
        .wl_data     (wl_data),
        .issue_load  (issue_load),
        .issue_rd    (issue_rd),
        .ra1_addr    (ra1_addr),
        .ra1_data    (ra1_data),
        .ra1_busy    (ra1_busy),
        .ra2_addr    (ra2_addr),
        .ra2_data    (ra2_data),
        .ra2_busy    (ra2_busy),
        .wb_conflict (wb_conflict)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: indexed by the full address space for simplicity.
    logic [XLEN-1:0] m_regs [NADDR];
    logic            m_busy [NADDR];
    logic            m_conf;

    function automatic bit legal(int a);
        return (a != 0) && (a < NREGS);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int a);
        logic [XLEN-1:0] v;
        if (!legal(a)) return '0;
        v = m_regs[a];
`ifdef WB_BYPASS_EN
        if (wa_en && legal(int'(wa_addr)) && int'(wa_addr) == a) v = wa_data;
        else if (wl_en && legal(int'(wl_addr)) && int'(wl_addr) == a) v = wl_data;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(int a);
        if (!legal(a)) return 1'b0;
`ifdef WB_BYPASS_EN
        if (wl_en && int'(wl_addr) == a &&
            !(issue_load && int'(issue_rd) == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NADDR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        m_conf = wa_en && wl_en && legal(int'(wa_addr)) && (wa_addr == wl_addr);
        if (wl_en && legal(int'(wl_addr))) begin
            m_regs[wl_addr] = wl_data;
            m_busy[wl_addr] = 1'b0;
        end
        if (wa_en && legal(int'(wa_addr))) m_regs[wa_addr] = wa_data;
        if (issue_load && legal(int'(issue_rd))) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_clear();
        else model_edge();
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wl_en = 1'b0; wl_addr = '0; wl_data = '0;
        issue_load = 1'b0; issue_rd = '0;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rd1"},  ra1_data, exp_data(int'(ra1_addr)));
        chk({tag, ".bz1"},  XLEN'(ra1_busy), XLEN'(exp_busy(int'(ra1_addr))));
        chk({tag, ".rd2"},  ra2_data, exp_data(int'(ra2_addr)));
        chk({tag, ".bz2"},  XLEN'(ra2_busy), XLEN'(exp_busy(int'(ra2_addr))));
        chk({tag, ".conf"}, XLEN'(wb_conflict), XLEN'(m_conf));
    endtask

    initial begin
        logic [XLEN-1:0] old_x2;
        reset = 1'b1;
        idle();
        ra1_addr = '0;
        ra2_addr = '0;
        model_clear();
        #12;
        chk("rst_rd1", ra1_data, '0);
        chk("rst_conf", XLEN'(wb_conflict), '0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Write x5 and mark x6 busy, then reset in the middle of a cycle.
        wa_en = 1'b1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        issue_load = 1'b1; issue_rd = 6;
        tick();
        idle(); ra1_addr = 5; ra2_addr = 6; #2;
        chk("x5_written", ra1_data, 32'hDEADBEEF);
        chk("x6_busy", XLEN'(ra2_busy), 1);
        wa_en = 1'b1; wa_addr = 5; wa_data = 32'h00000001;
        #2 reset = 1'b1; #1;
        chk("midrst_x5", ra1_data, '0);
        chk("midrst_conf", XLEN'(wb_conflict), '0);
        tick();
        reset = 1'b0; idle();
        for (int a = 0; a < 20; a++) begin
            ra1_addr = AW'(a); #1;
            chk($sformatf("postrst_d%0d", a), ra1_data, '0);
            chk($sformatf("postrst_b%0d", a), XLEN'(ra1_busy), '0);
        end
        @(posedge clock); #1;

        // Zero register ignores writes.
        wa_en = 1'b1; wa_addr = 0; wa_data = 32'h12345678;
        tick();
        idle(); ra1_addr = 0; #2;
        chk("x0_zero", ra1_data, '0);

        // Dual write to different registers.
        wa_en = 1'b1; wa_addr = 3; wa_data = 32'h11;
        wl_en = 1'b1; wl_addr = 4; wl_data = 32'h22;
        ra1_addr = 3; ra2_addr = 4; #2;
        chk_all("dual_diff_pre");
        tick();
        idle(); #2;
        chk("dual_x3", ra1_data, 32'h11);
        chk("dual_x4", ra2_data, 32'h22);
        chk("dual_conf", XLEN'(wb_conflict), '0);

        // Dual write to the same register: ALU wins, conflict pulses once.
        wa_en = 1'b1; wa_addr = 7; wa_data = 32'hAAAA0000;
        wl_en = 1'b1; wl_addr = 7; wl_data = 32'h5555FFFF;
        tick();
        idle(); ra1_addr = 7; #2;
        chk("coll_x7", ra1_data, 32'hAAAA0000);
        chk("coll_conf1", XLEN'(wb_conflict), 1);
        tick(); #2;
        chk("coll_conf0", XLEN'(wb_conflict), '0);

        // Scoreboard set, clear, and set-wins.
        issue_load = 1'b1; issue_rd = 9;
        tick();
        idle(); ra1_addr = 9; #2;
        chk("sb_set", XLEN'(ra1_busy), 1);
        wl_en = 1'b1; wl_addr = 9; wl_data = 32'h42;
        tick();
        idle(); #2;
        chk("sb_clr_busy", XLEN'(ra1_busy), '0);
        chk("sb_clr_data", ra1_data, 32'h42);
        issue_load = 1'b1; issue_rd = 9;
        wl_en = 1'b1; wl_addr = 9; wl_data = 32'h77;
        tick();
        idle(); #2;
        chk("sb_setwins", XLEN'(ra1_busy), 1);
        chk("sb_setwins_d", ra1_data, 32'h77);

        // Same-cycle write and read of x2.
        old_x2 = m_regs[2];
        wa_en = 1'b1; wa_addr = 2; wa_data = 32'h99;
        ra1_addr = 2; #2;
`ifdef WB_BYPASS_EN
        chk("byp_same", ra1_data, 32'h99);
`else
        chk("byp_same", ra1_data, old_x2);
`endif
        tick();
        idle(); #2;
        chk("byp_next", ra1_data, 32'h99);

        // Out-of-range addresses change nothing and read as zero.
        wa_en = 1'b1; wa_addr = 20; wa_data = 32'hFFFF_FFFF;
        wl_en = 1'b1; wl_addr = 21; wl_data = 32'hCAFE_F00D;
        issue_load = 1'b1; issue_rd = 20;
        tick();
        idle(); ra1_addr = 20; #2;
        chk("oor_data", ra1_data, '0);
        chk("oor_busy", XLEN'(ra1_busy), '0);
        for (int a = 0; a < NREGS; a++) begin
            ra1_addr = AW'(a); ra2_addr = AW'(a); #1;
            chk_all($sformatf("oor_keep%0d", a));
        end
        @(posedge clock); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wa_en      = ($urandom_range(0, 3) != 0);
            wa_addr    = AW'($urandom_range(0, 19));
            wa_data    = $urandom;
            wl_en      = ($urandom_range(0, 2) == 0);
            wl_addr    = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, 19));
            wl_data    = $urandom;
            issue_load = ($urandom_range(0, 2) == 0);
            issue_rd   = ($urandom_range(0, 3) == 0) ? wl_addr : AW'($urandom_range(0, 19));
            ra1_addr   = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, 19));
            ra2_addr   = ($urandom_range(0, 3) == 0) ? wl_addr : AW'($urandom_range(0, 19));
            #2;
            chk_all($sformatf("rand%0d", n));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Parametrised writeback register file for the pipeline; successor to the fixed 11-entry single-write-port writeback store.
- Two write ports:
  - ALU result port, driven from the execute/memory register.
  - Load-return port, driven from data memory.
- Two combinational read ports for decode.
- Per-register busy scoreboard: decode stalls on a register with a pending load.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (legal range 2..2**AW).
- AW, 5, address width of all address ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears array, scoreboard, flags.
- wa_en  input  1  ALU writeback enable.
- wa_addr  input  AW  ALU destination register.
- wa_data  input  XLEN  ALU result.
- wl_en  input  1  load writeback enable.
- wl_addr  input  AW  load destination register.
- wl_data  input  XLEN  load data.
- issue_load  input  1  decode issued a load this cycle; marks issue_rd busy.
- issue_rd  input  AW  destination of the issued load.
- ra1_addr  input  AW  read port 1 address.
- ra1_data  output  XLEN  read port 1 data.
- ra1_busy  output  1  read port 1 register has a pending load.
- ra2_addr  input  AW  read port 2 address.
- ra2_data  output  XLEN  read port 2 data.
- ra2_busy  output  1  read port 2 register has a pending load.
- wb_conflict  output  1  registered flag: previous cycle had both write ports targeting the same register.

Behaviour:
- Reset (asynchronous, active-high):
  - All NREGS registers become 0.
  - All busy bits become 0.
  - wb_conflict becomes 0.
  - Reset asserted mid-operation discards any in-flight write in that cycle.
- Writes occur at the rising clock edge. Write-to-read latency is 1 cycle without the optional feature.
- Address filtering (applies to both write ports and to issue_load):
  - Write to address 0 when ZERO_REG=1 is dropped.
  - Write to address >= NREGS is dropped.
- Write-port collision (wa_en and wl_en both high, same legal address):
  - The ALU port wins; the load data is discarded.
  - wb_conflict is 1 in the following cycle only.
  - wb_conflict stays 0 for different addresses, or when the collision address is dropped by address filtering.
- Different addresses on the two write ports: both writes complete in the same cycle.
- Scoreboard:
  - issue_load sets busy[issue_rd] at the edge.
  - wl_en clears busy[wl_addr] at the edge.
  - If set and clear hit the same register in one cycle, set wins (a new load is outstanding).
  - wa_en does not affect busy bits.
  - Busy bit 0 is never set when ZERO_REG=1.
  - Illegal addresses are ignored.
- Reads (combinational):
  - rN_data = array[raN_addr]; rN_busy = busy[raN_addr].
  - Address 0 with ZERO_REG=1 reads data 0, busy 0.
  - Address >= NREGS reads data 0, busy 0.
- No internal FSM beyond the array, the busy vector and the conflict flop.
- Data is stored unmodified; no width conversion.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-to-read forwarding.
  - A read whose address matches an active, legal write in the same cycle returns the write data.
  - ALU data takes priority over load data when both ports match.
  - rN_busy is forced to 0 when the matching active write is wl_en, unless issue_load to the same register is also active that cycle.
- Undefined: reads return pre-edge array contents and pre-edge busy; 1-cycle write-to-read latency.
- Addresses 0 (ZERO_REG=1) and >= NREGS are never forwarded, in either case.

Test Plan:
- Reset and zero register:
  - Write 0xDEADBEEF to x5, then assert reset mid-cycle -> ra1_data(x5)=0 immediately, busy all 0, wb_conflict=0.
  - wa_en to x0 with 0x12345678 -> ra1_data(x0)=0.
- Dual write, different addresses: wa to x3=0x11, wl to x4=0x22 in one cycle -> next cycle ra1(x3)=0x11, ra2(x4)=0x22, wb_conflict=0.
- Dual write, same address: wa x7=0xAAAA0000, wl x7=0x5555FFFF -> ra1(x7)=0xAAAA0000; wb_conflict=1 for exactly one cycle, then 0.
- Scoreboard:
  - issue_load x9 -> ra1_busy(x9)=1 next cycle.
  - wl x9=0x42 -> busy 0, data 0x42.
  - issue_load x9 together with wl x9 -> busy stays 1.
- Bypass with WB_BYPASS_EN:
  - Same-cycle wa x2=0x99 and read x2 -> ra1_data=0x99 in that cycle.
  - Without the macro -> old value in that cycle, 0x99 one cycle later.
- Out of range, NREGS=16 build: write to x20 -> no register changes; ra1(x20)=0, ra1_busy=0.
